// File: rtl/qspi_rx_fifo.sv
// Receive-data FIFO between qspi_fsm and the register front-end: level count, almost-full,
// sticky overflow/underflow, synchronous flush. Define QSPI_RX_FIFO_FWFT_EN for first-word-fall-through reads.
module qspi_rx_fifo #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AFULL = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf_evt;
  logic              udf_evt;

  // Accept decisions use the registered full/empty; flush suppresses all traffic and errors.
  assign wr_ok   = wr_en && !full  && !flush;
  assign rd_ok   = rd_en && !empty && !flush;
  assign ovf_evt = wr_en &&  full  && !flush;
  assign udf_evt = rd_en &&  empty && !flush;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_nxt = level;
    if (wr_ok && !rd_ok)
      level_nxt = level + LVL_ONE;
    else if (rd_ok && !wr_ok)
      level_nxt = level - LVL_ONE;
  end

  // NOTE: storage is deliberately left out of reset; only pointers and flags are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset)
      mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      // Error set wins over a coincident clear.
      overflow  <= (overflow  && !clr_err) || ovf_evt;
      underflow <= (underflow && !clr_err) || udf_evt;
      if (flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        level       <= '0;
        full        <= 1'b0;
        empty       <= 1'b1;
        almost_full <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
        level       <= level_nxt;
        full        <= (level_nxt == LVL_FULL);
        empty       <= (level_nxt == '0);
        almost_full <= (level_nxt >= LVL_AFULL);
      end
    end
  end

`ifdef QSPI_RX_FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en only acknowledges it.
  assign rd_data  = empty ? '0 : mem[rd_ptr];
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok)
        rd_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: doc/qspi_rx_fifo.md
Name: qspi_rx_fifo

Overview:
Receive-data buffer between qspi_fsm and the register/bus front-end.
- Write side accepts 32-bit words from qspi_fsm on rx_wen/rx_data_fifo and returns backpressure through rx_full.
- Read side is drained by the register block.
- Provides a level count, an almost-full threshold, sticky overflow/underflow error flags and a synchronous flush for aborted transfers.

Parameters:
DATA_W, 32, data word width (matches qspi_fsm rx_data_fifo)
DEPTH, 16, number of entries; power of two, >= 2
AFULL_THRESH, 12, level at or above which almost_full asserts; 1..DEPTH
(localparam ADDR_W = $clog2(DEPTH))

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  single-cycle pulse: discard all contents
wr_en  in  1  write strobe (driven by qspi_fsm rx_wen)
wr_data  in  DATA_W  write word (qspi_fsm rx_data_fifo)
full  out  1  FIFO full (to qspi_fsm rx_full)
rd_en  in  1  read/pop strobe from register block
rd_data  out  DATA_W  read word
rd_valid  out  1  rd_data qualifier (see Optional Feature)
empty  out  1  FIFO empty
level  out  ADDR_W+1  current entry count, 0..DEPTH
almost_full  out  1  level >= AFULL_THRESH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow and underflow

Behaviour:
- Reset values: full=0, empty=1, level=0, almost_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0, read/write pointers=0. Memory contents are not reset.
- Pointers are ADDR_W bits wide and wrap modulo DEPTH. level is a registered counter, not derived from pointer difference. full=(level==DEPTH), empty=(level==0), almost_full=(level>=AFULL_THRESH); all three are registered and consistent with level in the same cycle.
- Write accepted iff wr_en && !full, evaluated on full as registered at the start of the cycle. An accepted write stores wr_data at wr_ptr and increments wr_ptr.
- Read accepted iff rd_en && !empty, evaluated the same way. An accepted read increments rd_ptr.
- Simultaneous accepted read and write: level unchanged; pointers both advance. Legal at any level from 1 to DEPTH-1.
- Full with wr_en && rd_en: the read is accepted, the write is dropped, overflow is set. Next cycle level=DEPTH-1 and full=0.
- Empty with wr_en && rd_en: the write is accepted, the read is dropped, underflow is set. Next cycle level=1.
- Dropped write with no read: memory and pointers are untouched; overflow is set.
- Dropped read: pointers untouched, rd_data holds its previous value; underflow is set.
- flush has priority over wr_en/rd_en in the same cycle.
  - Next cycle: pointers=0, level=0, empty=1, full=0, almost_full=0, rd_valid=0.
  - Nothing is written or read in the flush cycle, and no error flags are set by it.
  - flush does not clear overflow/underflow.
- clr_err clears both sticky flags next cycle. If an error event occurs in the same cycle as clr_err, set wins.
- reset asserted mid-stream overrides everything and restores all reset values the next cycle.
- Write-to-read latency: a word written into an empty FIFO makes empty=0 one cycle after the write edge. It is readable from that cycle on.

Optional Feature:
Macro QSPI_RX_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data continuously presents mem[rd_ptr] whenever empty=0.
  - rd_valid = !empty.
  - rd_en acts as an acknowledge and pops the head. The next entry appears the cycle after the pop.
  - rd_data is don't-care while empty=1.
- Undefined (standard):
  - An accepted read registers mem[rd_ptr] into rd_data at the next edge and pulses rd_valid high for exactly one cycle.
  - rd_data holds its value otherwise.
  - Back-to-back rd_en gives one word per cycle, each with rd_valid.

Test Plan:
- Reset, then write 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, then read 3 -> data returned in order; level goes 1,2,3 then 2,1,0; empty=1 at the end. Standard mode: rd_valid high 1 cycle after each rd_en.
- Fill DEPTH=16 entries -> almost_full rises when level reaches 12; full=1 at 16. A 17th write of 0xDEADBEEF -> overflow=1, level stays 16, and the first read returns the first word written, not 0xDEADBEEF.
- At level 16, assert wr_en and rd_en together -> level=15, full=0, overflow=1. At level 0, assert both -> level=1, underflow=1, and the following read returns the written word.
- Write/read 40 words streaming with simultaneous wr_en/rd_en, wrapping the pointers twice -> all 40 words returned in order, level constant at 1, no error flags.
- Write 5 words, then flush together with wr_en and rd_en -> next cycle level=0, empty=1, no error flags set. A subsequent write of 0xA5A5A5A5 then read returns 0xA5A5A5A5.
- Set overflow, then pulse clr_err -> flag clears. Pulse clr_err concurrently with a write to a full FIFO -> overflow remains 1. Assert reset at level 7 -> all outputs return to reset values the next cycle.
